mem_sdp_clr: RTL and testbench
==============================

Name: mem_sdp_clr

Overview:
- Parametrised successor to the 2K byte RAM: single-clock simple-dual-port RAM with byte-column write enables.
- Selectable read latency (1 or 2 cycles) with a read-valid strobe.
- Selectable read-during-write collision mode.
- Built-in clear sequencer that zero-fills the whole array, on command or automatically after reset.
- Serves as the generic backing store for the console's work RAM, the video line buffers and the cartridge RAM windows.

Parameters:
- NB_COL, 1, number of byte columns per word.
- COL_WIDTH, 8, bits per column (8 or 9).
- RAM_DEPTH, 2048, number of words; need not be a power of two.
- OUT_REG, 0, 0 = 1-cycle read latency; 1 = extra output register, giving 2-cycle latency.
- RDW_MODE, "READ_FIRST", same-address read/write collision behaviour; "READ_FIRST" or "WRITE_FIRST".
- CLR_ON_RST, 0, 1 = start a clear sweep automatically on the first cycle after rstb deasserts.
- AW, clog2(RAM_DEPTH), derived address width; not for override.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rstb  in  1  synchronous active-high reset; clears control state and output registers, never array contents.
- clr  in  1  clear request pulse; sampled only in IDLE.
- busy  out  1  high while the clear sweep runs.
- addrW  in  AW  write address.
- Din  in  NB_COL*COL_WIDTH  write data.
- we  in  NB_COL  per-column write enable.
- addrR  in  AW  read address.
- re  in  1  read enable.
- regceb  in  1  output-register clock enable; used only when OUT_REG=1.
- Dout  out  NB_COL*COL_WIDTH  read data.
- rvalid  out  1  Dout carries the data of an accepted read.

Behaviour:
- Reset (rstb=1 at a clock edge):
  - Dout=0, rvalid=0, busy=0, FSM=IDLE, sweep counter=0. RAM contents are untouched.
  - rstb has priority over every other input.
  - A reset during a sweep aborts it. Already-swept words stay zero; the rest keep their old values.
- Write: at the edge, for each i with we[i]=1 and busy=0 and addrW<RAM_DEPTH, column i of RAM[addrW] takes Din column i. Other columns are unchanged.
- Read acceptance: a read is accepted when re=1, busy=0 and rstb=0.
- Read stage 1: an accepted read loads the stage-1 register with RAM[addrR]. If addrR>=RAM_DEPTH it loads 0. If re=0, stage 1 holds its value.
- Read latency with OUT_REG=0:
  - Dout is the stage-1 register; latency is 1 cycle.
  - rvalid is high for the cycle following each accepted read, else 0.
- Read latency with OUT_REG=1:
  - The stage-2 register loads stage 1 when regceb=1 and holds otherwise; Dout is stage 2.
  - rvalid stage 2 loads the stage-1 valid bit when regceb=1 and holds otherwise.
  - Latency is 2 cycles with regceb held at 1.
- Collision (re=1, we!=0, addrR==addrW, same edge), per column:
  - READ_FIRST: the column returns the pre-write value.
  - WRITE_FIRST: the column returns Din where we[i]=1, otherwise the stored value.
- Clear FSM, IDLE to CLEAR:
  - In IDLE, clr=1 (or the first post-reset cycle when CLR_ON_RST=1) moves to CLEAR on the next edge; counter=0.
  - busy rises in the same cycle CLEAR is entered.
- Clear FSM, CLEAR state:
  - Each cycle writes all-zero to RAM[counter] and increments the counter.
  - When the counter reaches RAM_DEPTH-1, that word is written and the FSM returns to IDLE.
  - busy is high for exactly RAM_DEPTH cycles.
- While busy:
  - we is ignored and re is ignored (no rvalid).
  - clr is ignored, so no restart occurs.
  - Reads accepted before the sweep still drain through the pipeline normally.
- clr and we in the same IDLE cycle: the write completes, then the sweep starts on the next cycle and overwrites it with zero.

Test Plan:
- Defaults; write i[7:0] to every address 0..2047, then read each address with re=1 -> Dout==i[7:0] exactly 1 cycle after re, rvalid high on that cycle only.
- NB_COL=2, OUT_REG=1; write 0xAABB to addr 5, then write with we=2'b01 and Din=0x1122 -> read returns 0xAA22 two cycles later. With regceb=0, Dout and rvalid hold.
- Collision: RAM[7]=0x55, then write 0x99 and read addr 7 in the same cycle -> READ_FIRST gives Dout=0x55; WRITE_FIRST gives Dout=0x99.
- RAM_DEPTH=1000 -> write to addr 1010 has no effect; read of 1010 returns 0 with rvalid=1.
- Fill with 0xFF, pulse clr -> busy high for exactly 2048 cycles. we and re are ignored and rvalid stays 0 during the sweep. Afterwards every address reads 0.
- Assert rstb mid-sweep at counter=100 -> busy=0 and Dout=0 the next cycle; addrs 0..99 read 0 and 100..2047 read 0xFF. With CLR_ON_RST=1 a full sweep starts immediately after rstb deasserts.

Source files
------------

// File: rtl/mem_sdp_clr.sv
// Single-clock simple-dual-port RAM with byte-column write enables and a built-in zero-fill sequencer.
// Latency: read data 1 cycle after an accepted read (OUT_REG=0) or 2 cycles with regceb held high (OUT_REG=1).
// Backpressure: none; while busy (clear sweep) writes, reads and clr are ignored, in-flight reads still drain.
//
// Ports:
//   clk, rstb        clock, synchronous active-high reset (array contents are never reset)
//   clr / busy       clear request pulse (taken in IDLE) / high for the RAM_DEPTH cycles of a sweep
//   addrW, Din, we   write port, per-column enables
//   addrR, re        read port
//   regceb           output-register clock enable (OUT_REG=1 only)
//   Dout, rvalid     read data and its valid strobe
module mem_sdp_clr #(
    parameter int    NB_COL     = 1,
    parameter int    COL_WIDTH  = 8,
    parameter int    RAM_DEPTH  = 2048,
    parameter int    OUT_REG    = 0,
    parameter string RDW_MODE   = "READ_FIRST",
    parameter int    CLR_ON_RST = 0,
    parameter int    AW         = $clog2(RAM_DEPTH)
) (
    input  logic                        clk,
    input  logic                        rstb,
    input  logic                        clr,
    output logic                        busy,
    input  logic [AW-1:0]               addrW,
    input  logic [NB_COL*COL_WIDTH-1:0] Din,
    input  logic [NB_COL-1:0]           we,
    input  logic [AW-1:0]               addrR,
    input  logic                        re,
    input  logic                        regceb,
    output logic [NB_COL*COL_WIDTH-1:0] Dout,
    output logic                        rvalid
);

    localparam int            DW        = NB_COL * COL_WIDTH;
    // One extra bit so the range compare works when RAM_DEPTH is a power of two.
    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(RAM_DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_DEPTH - 1);
    localparam bit            WR_FIRST  = (RDW_MODE == "WRITE_FIRST");

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          pend_q;      // auto-clear armed by reset, consumed on the first cycle out of reset

    logic [DW-1:0] mem [RAM_DEPTH];

    logic          wr_ok;
    logic          clr_wr;
    logic          rd_acc;
    logic          rd_in_range;
    logic [DW-1:0] rd_word;
    logic [DW-1:0] s1_dat;
    logic          s1_vld;

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rstb) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= (CLR_ON_RST != 0);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clr || pend_q) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                // The last word is written in this cycle; leave the counter parked at zero.
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy = (state_q == ST_CLEAR);

    // ------------------------------------------------------------------
    // Array write: sweep zeroes win; user writes only in IDLE and in range.
    // Reset blocks both so an aborted sweep leaves the current word intact.
    // ------------------------------------------------------------------
    assign wr_ok  = !rstb && !busy && ({1'b0, addrW} < DEPTH_W);
    assign clr_wr = !rstb && busy;

    always_ff @(posedge clk) begin
        if (clr_wr) begin
            mem[cnt_q] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < NB_COL; i++) begin
                if (we[i]) begin
                    mem[addrW][i*COL_WIDTH +: COL_WIDTH] <= Din[i*COL_WIDTH +: COL_WIDTH];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path. mem is sampled before this edge's write lands, which gives
    // READ_FIRST naturally; WRITE_FIRST patches in the written columns.
    // ------------------------------------------------------------------
    assign rd_acc      = re && !busy && !rstb;
    assign rd_in_range = ({1'b0, addrR} < DEPTH_W);

    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[addrR];
            if (WR_FIRST && wr_ok && (addrW == addrR)) begin
                for (int i = 0; i < NB_COL; i++) begin
                    if (we[i]) begin
                        rd_word[i*COL_WIDTH +: COL_WIDTH] = Din[i*COL_WIDTH +: COL_WIDTH];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            s1_dat <= '0;
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= rd_acc;
            if (rd_acc) begin
                s1_dat <= rd_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DW-1:0] s2_dat;
            logic          s2_vld;

            // Valid travels with data, so a stalled stage 2 keeps presenting the same beat.
            always_ff @(posedge clk) begin
                if (rstb) begin
                    s2_dat <= '0;
                    s2_vld <= 1'b0;
                end else if (regceb) begin
                    s2_dat <= s1_dat;
                    s2_vld <= s1_vld;
                end
            end

            assign Dout   = s2_dat;
            assign rvalid = s2_vld;
        end else begin : g_noreg
            logic unused_regceb;
            assign unused_regceb = regceb;
            assign Dout          = s1_dat;
            assign rvalid        = s1_vld;
        end
    endgenerate

endmodule

// File: tb/tb_mem_sdp_clr.sv
module tb_mem_sdp_clr;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int cmp_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic [15:0] dat;
        int          due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // ---------------- u0: defaults (1 col, 2048 deep, 1-cycle, READ_FIRST)
    logic        rstb0, clr0, busy0, re0, regceb0, rvalid0;
    logic [10:0] addrW0, addrR0;
    logic [7:0]  Din0, Dout0;
    logic [0:0]  we0;

    mem_sdp_clr u0 (
        .clk(clk), .rstb(rstb0), .clr(clr0), .busy(busy0),
        .addrW(addrW0), .Din(Din0), .we(we0),
        .addrR(addrR0), .re(re0), .regceb(regceb0),
        .Dout(Dout0), .rvalid(rvalid0)
    );

    // ---------------- u1: 2 cols, 1000 deep, output register, WRITE_FIRST, clear on reset
    logic        rstb1, clr1, busy1, re1, regceb1, rvalid1;
    logic [9:0]  addrW1, addrR1;
    logic [15:0] Din1, Dout1;
    logic [1:0]  we1;

    mem_sdp_clr #(
        .NB_COL(2), .COL_WIDTH(8), .RAM_DEPTH(1000), .OUT_REG(1),
        .RDW_MODE("WRITE_FIRST"), .CLR_ON_RST(1)
    ) u1 (
        .clk(clk), .rstb(rstb1), .clr(clr1), .busy(busy1),
        .addrW(addrW1), .Din(Din1), .we(we1),
        .addrR(addrR1), .re(re1), .regceb(regceb1),
        .Dout(Dout1), .rvalid(rvalid1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitors
    always @(negedge clk) begin : mon0
        exp_t e;
        if (rvalid0 === 1'b1) begin
            if (q0.size() == 0) begin
                cmp_cnt++;
                err_cnt++;
                $display("FAIL u0_spurious_rvalid: got rvalid=1 Dout=%0h expected no outstanding read (t=%0t)", Dout0, $time);
            end else begin
                e = q0.pop_front();
                check("u0_rdata", {24'h0, Dout0}, {16'h0, e.dat});
                check("u0_latency", cyc, e.due);
            end
        end
    end

    // Stage 2 only presents a new beat on cycles where regceb was high at the edge.
    logic regceb1_q = 1'b0;
    always @(posedge clk) regceb1_q <= regceb1;

    always @(negedge clk) begin : mon1
        exp_t e;
        if (rvalid1 === 1'b1 && regceb1_q) begin
            if (q1.size() == 0) begin
                cmp_cnt++;
                err_cnt++;
                $display("FAIL u1_spurious_rvalid: got rvalid=1 Dout=%0h expected no outstanding read (t=%0t)", Dout1, $time);
            end else begin
                e = q1.pop_front();
                check("u1_rdata", {16'h0, Dout1}, {16'h0, e.dat});
                if (e.due >= 0) check("u1_latency", cyc, e.due);
            end
        end
    end

    // ---------------- stimulus helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr0(input int a, input logic [7:0] d);
        addrW0 = 11'(a); Din0 = d; we0 = 1'b1;
        tick();
        we0 = 1'b0;
    endtask

    task automatic rd0(input int a, input logic [7:0] d);
        addrR0 = 11'(a); re0 = 1'b1;
        q0.push_back('{dat: {8'h0, d}, due: cyc + 1});
        tick();
        re0 = 1'b0;
    endtask

    task automatic wr1(input int a, input logic [15:0] d, input logic [1:0] w);
        addrW1 = 10'(a); Din1 = d; we1 = w;
        tick();
        we1 = 2'b00;
    endtask

    task automatic rd1(input int a, input logic [15:0] d);
        addrR1 = 10'(a); re1 = 1'b1;
        q1.push_back('{dat: d, due: cyc + 2});
        tick();
        re1 = 1'b0;
    endtask

    // Counts consecutive busy cycles starting at the next falling edge.
    task automatic count_busy(input int which, output int n);
        n = 0;
        @(negedge clk);
        while (((which == 0) ? busy0 : busy1) === 1'b1 && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation still running at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rstb0 = 1'b1; clr0 = 1'b0; re0 = 1'b0; regceb0 = 1'b1;
        addrW0 = '0; addrR0 = '0; Din0 = '0; we0 = '0;
        rstb1 = 1'b1; clr1 = 1'b0; re1 = 1'b0; regceb1 = 1'b1;
        addrW1 = '0; addrR1 = '0; Din1 = '0; we1 = '0;

        // ================= u0 =================
        repeat (2) tick();
        @(negedge clk);
        check("u0_rst_dout", {24'h0, Dout0}, 32'h0);
        check("u0_rst_rvalid", {31'h0, rvalid0}, 32'h0);
        check("u0_rst_busy", {31'h0, busy0}, 32'h0);
        rstb0 = 1'b0;
        tick();
        @(negedge clk);
        check("u0_no_auto_clear", {31'h0, busy0}, 32'h0);

        for (int i = 0; i < 2048; i++) wr0(i, 8'(i));
        for (int i = 0; i < 2048; i++) rd0(i, 8'(i));
        tick();
        @(negedge clk);
        check("u0_rvalid_drops", {31'h0, rvalid0}, 32'h0);

        // same-address collision, READ_FIRST
        wr0(7, 8'h55);
        addrW0 = 11'd7; Din0 = 8'h99; we0 = 1'b1; addrR0 = 11'd7; re0 = 1'b1;
        q0.push_back('{dat: 16'h0055, due: cyc + 1});
        tick();
        we0 = 1'b0; re0 = 1'b0;
        rd0(7, 8'h99);

        // full sweep with we/re/clr held active throughout
        for (int i = 0; i < 2048; i++) wr0(i, 8'hFF);
        clr0 = 1'b1;
        tick();
        addrW0 = 11'd0; Din0 = 8'hAB; we0 = 1'b1; addrR0 = 11'd5; re0 = 1'b1;
        count_busy(0, n);
        we0 = 1'b0; re0 = 1'b0; clr0 = 1'b0;
        check("u0_busy_cycles", n, 2048);
        for (int i = 0; i < 2048; i++) rd0(i, 8'h00);

        // reset mid-sweep at counter=100; a read issued with clr still drains
        for (int i = 0; i < 2048; i++) wr0(i, 8'hFF);
        addrR0 = 11'd3; re0 = 1'b1; clr0 = 1'b1;
        q0.push_back('{dat: 16'h00FF, due: cyc + 1});
        tick();
        re0 = 1'b0; clr0 = 1'b0;
        repeat (100) tick();
        rstb0 = 1'b1;
        tick();
        @(negedge clk);
        check("u0_abort_busy", {31'h0, busy0}, 32'h0);
        check("u0_abort_dout", {24'h0, Dout0}, 32'h0);
        check("u0_abort_rvalid", {31'h0, rvalid0}, 32'h0);
        rstb0 = 1'b0;
        for (int i = 0; i < 2048; i++) rd0(i, (i < 100) ? 8'h00 : 8'hFF);
        repeat (3) tick();

        // ================= u1 =================
        @(negedge clk);
        check("u1_rst_dout", {16'h0, Dout1}, 32'h0);
        check("u1_rst_rvalid", {31'h0, rvalid1}, 32'h0);
        check("u1_rst_busy", {31'h0, busy1}, 32'h0);
        rstb1 = 1'b0;
        tick();
        addrR1 = 10'd0; re1 = 1'b1;
        count_busy(1, n);
        re1 = 1'b0;
        check("u1_auto_clear_cycles", n, 1000);
        rd1(0, 16'h0000);
        rd1(999, 16'h0000);

        // byte-column write
        wr1(8, 16'h1234, 2'b11);
        wr1(5, 16'hAABB, 2'b11);
        wr1(5, 16'h1122, 2'b01);
        rd1(5, 16'hAA22);
        tick();
        // stall stage 2: output and valid must hold while a new read sits in stage 1
        regceb1 = 1'b0; addrR1 = 10'd8; re1 = 1'b1;
        tick();
        re1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("u1_hold_dout", {16'h0, Dout1}, 32'hAA22);
            check("u1_hold_rvalid", {31'h0, rvalid1}, 32'h1);
            tick();
        end
        // stage 1 valid has since dropped, so the resumed beat carries data but no valid
        regceb1 = 1'b1;
        tick();
        @(negedge clk);
        check("u1_resume_dout", {16'h0, Dout1}, 32'h1234);
        check("u1_resume_rvalid", {31'h0, rvalid1}, 32'h0);

        // collisions, WRITE_FIRST, full and partial column enables
        wr1(7, 16'h0055, 2'b11);
        addrW1 = 10'd7; Din1 = 16'h0099; we1 = 2'b11; addrR1 = 10'd7; re1 = 1'b1;
        q1.push_back('{dat: 16'h0099, due: cyc + 2});
        tick();
        Din1 = 16'h7700; we1 = 2'b10;
        q1.push_back('{dat: 16'h7799, due: cyc + 2});
        tick();
        we1 = 2'b00; re1 = 1'b0;
        rd1(7, 16'h7799);

        // out-of-range and last-address accesses
        wr1(1010, 16'h1234, 2'b11);
        rd1(1010, 16'h0000);
        wr1(999, 16'hC0DE, 2'b11);
        rd1(999, 16'hC0DE);

        // write and clr in the same IDLE cycle: the sweep wins afterwards
        addrW1 = 10'd3; Din1 = 16'hBEEF; we1 = 2'b11; clr1 = 1'b1;
        tick();
        we1 = 2'b00; clr1 = 1'b0;
        count_busy(1, n);
        check("u1_clr_cycles", n, 1000);
        rd1(3, 16'h0000);
        rd1(999, 16'h0000);
        rd1(5, 16'h0000);

        repeat (4) tick();
        check("u0_queue_drained", q0.size(), 0);
        check("u1_queue_drained", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
